// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, status/control bit positions and TX FSM states
package uart_pkg;
    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;
    localparam int ST_RX_VALID   = 0;
    localparam int ST_PERR       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_FIFO_EMPTY = 3;
    localparam int ST_FIFO_FULL  = 4;
    localparam int ST_TX_BUSY    = 5;
    localparam int CTRL_PARITY   = 0;
    localparam int CTRL_RX_IE    = 1;
    localparam int CTRL_TX_IE    = 2;
    localparam int CTRL_CLR_OVR  = 7;
    typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; push to full and pop from empty are ignored
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-side UART controller with TX FIFO, frame pacing, RX capture and irq
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2500,
    parameter int FRAME_BITS   = 11,
    parameter int GUARD_CYCLES = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] tx_data,
    output logic       send,
    output logic       parity,
    input  logic [7:0] rx_data,
    input  logic       rdrf,
    input  logic       prty,
    output logic       rdrf_clr,
    output logic       rx_clr,
    output logic       irq
);
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT + GUARD_CYCLES;
    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
    tx_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic pop, fifo_full, fifo_empty, tx_busy;
    logic [7:0] fifo_dout, rx_hold, status, ctrl;
    logic tx_ie, rx_ie, rx_valid, overrun, perr;
    logic rdrf_s1, rdrf_s2, rdrf_d, cap;
    logic wr_tx, wr_ctrl, rd_rx;
    assign wr_tx = we && addr == ADDR_TXDATA;
    assign wr_ctrl = we && addr == ADDR_CTRL;
    assign rd_rx = re && addr == ADDR_RXDATA;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .clr_n(clr_n), .push(wr_tx), .pop(pop), .din(wdata),
        .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );
    // WAIT leaves one cycle early so strobes land FRAME_CYCLES+2 apart
    always_comb begin
        pop = state == IDLE && !fifo_empty;
        state_nx = state == IDLE ? (fifo_empty ? IDLE : LOAD) :
                   state == LOAD ? STROBE :
                   state == STROBE ? WAIT :
                   (cnt <= CW'(1) ? IDLE : WAIT);
    end
    assign send = state == STROBE;
    assign tx_busy = state != IDLE;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt <= '0;
            tx_data <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == STROBE ? CNT_LOAD : state == WAIT ? cnt - CW'(1) : cnt;
            if (pop) tx_data <= fifo_dout;
        end
    end
    assign cap = rdrf_s2 && !rdrf_d;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            {rdrf_s1, rdrf_s2, rdrf_d, rdrf_clr} <= '0;
            rx_hold <= '0;
            {rx_valid, perr, overrun} <= '0;
        end else begin
            rdrf_s1 <= rdrf;
            rdrf_s2 <= rdrf_s1;
            rdrf_d <= rdrf_s2;
            rdrf_clr <= cap;
            if (cap) begin
                rx_hold <= rx_data;
                perr <= prty;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                perr <= 1'b0;
                rx_valid <= 1'b0;
            end
            if (cap && rx_valid) overrun <= 1'b1;
            else if (wr_ctrl && wdata[CTRL_CLR_OVR]) overrun <= 1'b0;
        end
    end
    always_comb begin
        status = '0;
        status[ST_RX_VALID] = rx_valid;
        status[ST_PERR] = perr;
        status[ST_OVERRUN] = overrun;
        status[ST_FIFO_EMPTY] = fifo_empty;
        status[ST_FIFO_FULL] = fifo_full;
        status[ST_TX_BUSY] = tx_busy;
        ctrl = '0;
        ctrl[CTRL_PARITY] = parity;
        ctrl[CTRL_RX_IE] = rx_ie;
        ctrl[CTRL_TX_IE] = tx_ie;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            {tx_ie, rx_ie, parity} <= '0;
            rdata <= '0;
        end else begin
            if (wr_ctrl) begin
                tx_ie <= wdata[CTRL_TX_IE];
                rx_ie <= wdata[CTRL_RX_IE];
                if (!tx_busy && fifo_empty) parity <= wdata[CTRL_PARITY];
            end
            if (re) rdata <= addr == ADDR_RXDATA ? rx_hold :
                             addr == ADDR_STATUS ? status :
                             addr == ADDR_CTRL ? ctrl : 8'h00;
        end
    end
    assign rx_clr = ~clr_n;
    assign irq = (rx_ie && rx_valid) || (tx_ie && fifo_empty && !tx_busy);
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: scoreboard bench for uart_ctrl with CLKS_PER_BIT=4 (62-cycle send spacing)
module tb_uart_ctrl;
    logic clk = 0, clr_n = 0, we = 0, re = 0, rdrf = 0, prty = 0;
    logic [1:0] addr = 0;
    logic [7:0] wdata = 0, rx_data = 0;
    logic [7:0] rdata, tx_data;
    logic send, parity, rdrf_clr, rx_clr, irq;
    int n_cmp = 0, n_err = 0, cyc = 0, n_clr = 0, n_send = 0, t_push = 0;
    logic re_seen = 0;
    logic [7:0] exp_send[$], exp_rd[$];
    int send_t[$];

    uart_ctrl #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .clr_n(clr_n), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .tx_data(tx_data), .send(send), .parity(parity),
        .rx_data(rx_data), .rdrf(rdrf), .prty(prty), .rdrf_clr(rdrf_clr),
        .rx_clr(rx_clr), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        re_seen <= re;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (send) begin
            n_send++;
            send_t.push_back(cyc);
            if (exp_send.size() == 0) chk("unexpected_send", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else chk("tx_data", tx_data, exp_send.pop_front());
        end
        if (rdrf_clr) n_clr++;
        if (re_seen) begin
            if (exp_rd.size() == 0) chk("unexpected_read", {24'h0, rdata}, 32'hFFFF_FFFF);
            else chk("rdata", rdata, exp_rd.pop_front());
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1;
        @(negedge clk);
        we = 0;
        t_push = cyc;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [7:0] exp);
        exp_rd.push_back(exp);
        @(negedge clk);
        addr = a; re = 1;
        @(negedge clk);
        re = 0;
        @(negedge clk);
    endtask

    task automatic wait_sends();
        int n = 0;
        while (exp_send.size() != 0 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", exp_send.size(), 0);
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic p);
        @(negedge clk);
        rx_data = d; prty = p; rdrf = 1;
        repeat (4) @(negedge clk);
        rdrf = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int t0, c0;
        repeat (3) @(negedge clk);
        chk("send_rst", send, 0);
        chk("rdrf_clr_rst", rdrf_clr, 0);
        chk("rx_clr_rst", rx_clr, 1);
        chk("irq_rst", irq, 0);
        clr_n = 1;
        @(negedge clk);
        chk("rx_clr_run", rx_clr, 0);
        bus_rd(2'd2, 8'h08);
        bus_rd(2'd3, 8'h00);
        bus_rd(2'd0, 8'h00);

        send_t.delete();
        exp_send.push_back(8'hA5);
        exp_send.push_back(8'h3C);
        bus_wr(2'd0, 8'hA5);
        t0 = t_push;
        bus_wr(2'd0, 8'h3C);
        wait_sends();
        chk("first_send_latency", send_t[0] - t0, 2);
        chk("send_spacing", send_t[1] - send_t[0], 62);
        repeat (64) @(negedge clk);
        bus_rd(2'd2, 8'h08);

        send_t.delete();
        for (int i = 0; i < 5; i++) exp_send.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 8'h11 + 8'(i));
        wait_sends();
        for (int i = 1; i < 5; i++) chk("burst_spacing", send_t[i] - send_t[i-1], 62);
        repeat (64) @(negedge clk);

        c0 = n_send;
        exp_send.push_back(8'h20);
        bus_wr(2'd0, 8'h20);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) exp_send.push_back(8'h21 + 8'(i));
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 8'h21 + 8'(i));
        bus_rd(2'd2, 8'h30);
        wait_sends();
        repeat (130) @(negedge clk);
        chk("send_count_full", n_send - c0, 5);
        bus_rd(2'd2, 8'h08);

        c0 = n_clr;
        rx_pulse(8'h5A, 1'b1);
        chk("rdrf_clr_once", n_clr - c0, 1);
        bus_rd(2'd2, 8'h0B);
        bus_rd(2'd1, 8'h5A);
        bus_rd(2'd2, 8'h08);

        c0 = n_clr;
        rx_pulse(8'h01, 1'b0);
        rx_pulse(8'h02, 1'b0);
        chk("rdrf_clr_twice", n_clr - c0, 2);
        bus_rd(2'd2, 8'h0D);
        bus_rd(2'd1, 8'h02);
        bus_rd(2'd2, 8'h0C);
        bus_wr(2'd3, 8'h80);
        bus_rd(2'd2, 8'h08);

        exp_send.push_back(8'h30);
        bus_wr(2'd0, 8'h30);
        repeat (3) @(negedge clk);
        bus_wr(2'd3, 8'h01);
        chk("parity_busy", parity, 0);
        bus_rd(2'd3, 8'h00);
        wait_sends();
        repeat (64) @(negedge clk);
        bus_wr(2'd3, 8'h05);
        chk("parity_idle", parity, 1);
        chk("irq_tx_idle", irq, 1);
        bus_rd(2'd3, 8'h05);
        exp_send.push_back(8'h31);
        bus_wr(2'd0, 8'h31);
        repeat (3) @(negedge clk);
        chk("irq_tx_busy", irq, 0);
        wait_sends();
        repeat (64) @(negedge clk);
        chk("irq_tx_drained", irq, 1);

        bus_wr(2'd3, 8'h02);
        chk("irq_rx_none", irq, 0);
        rx_pulse(8'h77, 1'b0);
        chk("irq_rx", irq, 1);
        bus_rd(2'd1, 8'h77);
        chk("irq_rx_read", irq, 0);

        c0 = n_send;
        exp_send.push_back(8'h40);
        bus_wr(2'd0, 8'h40);
        bus_wr(2'd0, 8'h41);
        wait_sends();
        repeat (10) @(negedge clk);
        clr_n = 0;
        repeat (2) @(negedge clk);
        chk("send_in_rst", send, 0);
        clr_n = 1;
        repeat (130) @(negedge clk);
        chk("send_count_rst", n_send - c0, 1);
        bus_rd(2'd2, 8'h08);
        bus_rd(2'd3, 8'h00);
        chk("read_queue_empty", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
